gray_tick_counter_bank: RTL

Fast-domain counter bank that produces values safe to sample from a slower clock domain. A shared prescaler generates one increment opportunity every DIV cycles of clk1. Each of CHANNELS counters advances on that tick and publishes both a binary value and a registered Gray-coded value. The slow-domain consumer synchronises only the Gray bus, because it changes by exactly one bit per increment.

---
 rtl/gray_tick_pkg.sv | 26 ++
 rtl/gray_chan_counter.sv | 57 +++++
 rtl/gray_tick_counter_bank.sv | 57 +++++
 3 files changed

// File: rtl/gray_tick_pkg.sv
// Shared helpers for the Gray tick counter bank: code conversions and the
// prescaler width calculation.
package gray_tick_pkg;

  localparam int MAX_W = 32;

  // Prescaler needs at least one bit even when DIV is 1.
  function automatic int pre_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

  // Callers zero-extend narrower values and cast the result back to their width.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_chan_counter.sv
// One counter channel: binary and Gray registers updated together, with
// clear-over-increment priority and optional saturation at the top value.
module gray_chan_counter
  import gray_tick_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             tick,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] nb;
  logic             wrap_next;

  always_comb begin
    nb        = count_bin;
    wrap_next = 1'b0;
    if (clr) begin
      nb = '0;
    end else if (tick && en) begin
      if (count_bin == CNT_MAX) begin
        if (!SATURATE) begin
          nb        = '0;
          wrap_next = 1'b1;
        end
      end else begin
        nb = count_bin + WIDTH'(1);
      end
    end
  end

  // Gray is derived from the next binary value so both buses always agree.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      count_bin  <= '0;
      count_gray <= '0;
      wrap       <= 1'b0;
      at_max     <= 1'b0;
    end else begin
      count_bin  <= nb;
      count_gray <= WIDTH'(bin2gray(MAX_W'(nb)));
      wrap       <= wrap_next;
      at_max     <= (nb == CNT_MAX);
    end
  end

endmodule

// File: rtl/gray_tick_counter_bank.sv
// Bank of CHANNELS counters sharing one prescaler; each publishes a registered
// Gray value that a slower clock domain may synchronise safely.
module gray_tick_counter_bank
  import gray_tick_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIV      = 3,
  parameter int CHANNELS = 2,
  parameter int SATURATE = 0
) (
  input  logic                      clk1,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clr,
  output logic                      tick,
  output logic [CHANNELS*WIDTH-1:0] count_bin,
  output logic [CHANNELS*WIDTH-1:0] count_gray,
  output logic [CHANNELS-1:0]       wrap,
  output logic [CHANNELS-1:0]       at_max
);

  localparam int               PRE_W    = pre_width(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Decoded from the register, so with DIV=1 tick is high even during reset.
  assign tick = (pre == PRE_LAST);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    gray_chan_counter #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE != 0)
    ) u_chan (
      .clk1       (clk1),
      .reset      (reset),
      .tick       (tick),
      .en         (en[i]),
      .clr        (clr[i]),
      .count_bin  (count_bin[i*WIDTH +: WIDTH]),
      .count_gray (count_gray[i*WIDTH +: WIDTH]),
      .wrap       (wrap[i]),
      .at_max     (at_max[i])
    );
  end

endmodule
